// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a single-word
// holding register delivered on a valid/ack handshake with frame-error and overrun pulses.
module uart_rx #(
   parameter int unsigned ClkRate  = 100_000_000,
   parameter int unsigned BaudRate = 115200,
   parameter int unsigned WordSize = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                uart_i,
   output logic [WordSize-1:0] data_o,
   output logic                data_valid_o,
   input  logic                data_ack_i,
   output logic                frame_err_o,
   output logic                overrun_o
);

   localparam int unsigned CyclesPerBit = ClkRate / BaudRate;
   localparam int unsigned HalfBit      = CyclesPerBit / 2;
   localparam int unsigned CntW         = $clog2(CyclesPerBit);
   localparam int unsigned IdxW         = (WordSize > 1) ? $clog2(WordSize) : 1;

   localparam logic [CntW-1:0] BitLast  = CntW'(CyclesPerBit - 1);
   localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
   localparam logic [CntW-1:0] CntOne   = CntW'(1);
   localparam logic [IdxW-1:0] IdxLast  = IdxW'(WordSize - 1);
   localparam logic [IdxW-1:0] IdxOne   = IdxW'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_e;

   logic [1:0]          sync_q;
   logic                rx_s;
   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [WordSize-1:0] shift_q, shift_d;
   logic [WordSize-1:0] data_q, data_d;
   logic                valid_q, valid_d;
   logic                ferr_q, ferr_d;
   logic                ovr_q, ovr_d;
   logic                good_s;

   // Synchroniser resets to idle-high so leaving reset never fakes a start bit
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], uart_i};
      end
   end

   assign rx_s = sync_q[1];

   // Next-state, sampling and delivery logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
      good_s  = 1'b0;

      if (valid_q && data_ack_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (cnt_q == HalfLast) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d = DATA;
                  idx_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         DATA: begin
            if (cnt_q == BitLast) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[WordSize-1:1]};
               if (idx_q == IdxLast) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + IdxOne;
               end
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         STOP: begin
            if (cnt_q == BitLast) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = IDLE;
                  good_s  = 1'b1;
               end else begin
                  state_d = BREAK;
                  ferr_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         BREAK: begin
            if (rx_s) begin
               state_d = IDLE;
            end else begin
               state_d = BREAK;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // An ack in the same cycle frees the holding register for the new word
      if (good_s) begin
         if (!valid_q || data_ack_i) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else begin
         ovr_d = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign data_o       = data_q;
   assign data_valid_o = valid_q;
   assign frame_err_o  = ferr_q;
   assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame vectors from a table plus hand-written
// glitch, back-to-back and mid-frame reset sequences.
module tb_uart_rx;

   localparam int unsigned CLK_HZ = 10_000_000;
   localparam int unsigned BAUD   = 40_000;
   localparam int unsigned BIT    = CLK_HZ / BAUD;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       uart = 1'b1;
   logic       ack = 1'b0;
   logic [7:0] data;
   logic       valid, ferr, ovr;

   uart_rx #(.ClkRate(CLK_HZ), .BaudRate(BAUD), .WordSize(8)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .uart_i      (uart),
      .data_o      (data),
      .data_valid_o(valid),
      .data_ack_i  (ack),
      .frame_err_o (ferr),
      .overrun_o   (ovr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int ferr_cnt = 0, ovr_cnt = 0, rise_cnt = 0;
   int both_viol = 0, pulse_viol = 0, stab_viol = 0, x_viol = 0;
   logic       ferr_prev = 1'b0, ovr_prev = 1'b0, valid_prev = 1'b0, ack_prev = 1'b0;
   logic [7:0] data_prev = 8'h00;

   // Output monitor: pulse counts, pulse width, stability and X checks
   always @(negedge clk) begin
      if (rst) begin
         ferr_prev  <= 1'b0;
         ovr_prev   <= 1'b0;
         valid_prev <= 1'b0;
         ack_prev   <= 1'b0;
      end else begin
         if ($isunknown({data, valid, ferr, ovr})) x_viol <= x_viol + 1;
         if (ferr) ferr_cnt <= ferr_cnt + 1;
         if (ovr) ovr_cnt <= ovr_cnt + 1;
         if (ferr && ovr) both_viol <= both_viol + 1;
         if ((ferr && ferr_prev) || (ovr && ovr_prev)) pulse_viol <= pulse_viol + 1;
         if (valid_prev && !ack_prev && data !== data_prev) stab_viol <= stab_viol + 1;
         if (valid && !valid_prev) rise_cnt <= rise_cnt + 1;
         ferr_prev  <= ferr;
         ovr_prev   <= ovr;
         valid_prev <= valid;
         ack_prev   <= ack;
         data_prev  <= data;
      end
   end

   initial begin
      #600_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      uart = b;
      tick(BIT);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
      uart = 1'b1;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 12 * BIT; i++) begin
         if (valid) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   typedef struct {
      logic [7:0] word;
      logic       stop;
      logic       do_ack;
      logic       exp_valid;
      logic [7:0] exp_data;
      int         exp_ferr;
      int         exp_ovr;
      int         exp_rise;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int f0, o0, r0;
      bit ok;

      vecs[0] = '{8'hAB, 1'b1, 1'b1, 1'b1, 8'hAB, 0, 0, 1};
      vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 0, 0, 1};
      vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 0, 0, 1};
      vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 1, 0, 0};
      vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 0, 0, 1};
      vecs[5] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 0, 0, 1};
      vecs[6] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 0, 1, 0};
      vecs[7] = '{8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 0, 0, 1};

      // Reset and idle line
      rst = 1'b1;
      tick(100);
      check("rst_valid", valid, 1'b0);
      check("rst_data", data, 8'h00);
      check("rst_ferr", ferr, 1'b0);
      check("rst_ovr", ovr, 1'b0);
      rst = 1'b0;
      tick(2 * BIT);
      check("idle_valid", valid, 1'b0);
      check("idle_ferr_cnt", ferr_cnt, 0);
      check("idle_ovr_cnt", ovr_cnt, 0);

      // Glitch shorter than half a bit
      f0 = ferr_cnt;
      uart = 1'b0;
      tick(100);
      uart = 1'b1;
      tick(2 * BIT);
      check("glitch_valid", valid, 1'b0);
      check("glitch_ferr", ferr_cnt - f0, 0);

      // Table-driven frames; valid must already be up when the stop bit ends
      for (int v = 0; v < 8; v++) begin
         f0 = ferr_cnt;
         o0 = ovr_cnt;
         r0 = rise_cnt;
         send_frame(vecs[v].word, vecs[v].stop);
         check($sformatf("vec%0d_valid", v), valid, vecs[v].exp_valid);
         if (vecs[v].exp_valid) check($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
         check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
         check($sformatf("vec%0d_ovr", v), ovr_cnt - o0, vecs[v].exp_ovr);
         check($sformatf("vec%0d_rise", v), rise_cnt - r0, vecs[v].exp_rise);
         if (vecs[v].do_ack) begin
            do_ack();
            check($sformatf("vec%0d_drop", v), valid, 1'b0);
         end
         tick(BIT);
      end

      // Back-to-back frames with no idle gap
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      fork
         begin
            send_frame(8'hAB, 1'b1);
            send_frame(8'hBC, 1'b1);
         end
         begin
            wait_valid(ok);
            check("b2b_first_seen", ok, 1'b1);
            check("b2b_first_data", data, 8'hAB);
            do_ack();
            wait_valid(ok);
            check("b2b_second_seen", ok, 1'b1);
            check("b2b_second_data", data, 8'hBC);
            do_ack();
         end
      join
      tick(BIT);
      check("b2b_ferr", ferr_cnt - f0, 0);
      check("b2b_ovr", ovr_cnt - o0, 0);
      check("b2b_valid_low", valid, 1'b0);

      // Reset in the middle of a frame while a word is still held
      send_frame(8'h44, 1'b1);
      check("mid_pending", valid, 1'b1);
      tick(BIT);
      uart = 1'b0;
      tick(BIT);
      uart = 1'b1;
      tick(BIT / 2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("mid_rst_valid", valid, 1'b0);
      check("mid_rst_data", data, 8'h00);
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      tick(10 * BIT);
      check("mid_no_partial", valid, 1'b0);
      send_frame(8'h77, 1'b1);
      check("mid_after_valid", valid, 1'b1);
      check("mid_after_data", data, 8'h77);
      do_ack();
      tick(BIT);
      check("mid_ferr", ferr_cnt - f0, 0);
      check("mid_ovr", ovr_cnt - o0, 0);

      // Properties gathered by the monitor over the whole run
      check("never_both_pulses", both_viol, 0);
      check("pulse_width_one", pulse_viol, 0);
      check("data_stable_held", stab_viol, 0);
      check("no_x_outputs", x_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
